oqpsk_frame_ctrl: RTL and testbench
===================================

Name: oqpsk_frame_ctrl

Overview:
Frame sequencer that feeds the OQPSK pulse-shaping modulator.
- Accepts payload bytes over a valid/ready handshake.
- Emits a serial bit stream (preamble, sync word, payload MSB-first, zero tail) on mod_bit, one bit every BIT_DIV clocks.
- Gates the modulator enable (mod_en) for exactly the frame duration, so the modulator's filter is flushed before disable.
- Sits between the host/Wishbone-side logic and the modulator's EN/BitIn inputs.

Parameters:
BIT_DIV, 8, clocks per transmitted bit (>=2)
PREAMBLE_BITS, 32, alternating 1/0 bits before sync (even, >=2)
SYNC_LEN, 16, sync word length in bits (1..32)
SYNC_WORD, 32'h0000D391, sync pattern; low SYNC_LEN bits sent MSB-first
TAIL_BITS, 16, zero bits appended after payload for filter flush (>=1)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
start  in  1  frame request, sampled only in IDLE
len  in  8  payload byte count, latched on accepted start (0 = no payload)
byte_data  in  8  payload byte
byte_valid  in  1  byte_data valid
byte_ready  out  1  holding register can accept a byte
mod_en  out  1  modulator enable (EN)
mod_bit  out  1  modulator bit input (BitIn)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at frame end
underrun  out  1  sticky; payload byte missing at a byte boundary

Behaviour:
Reset values (RST low, asynchronous):
- State IDLE; all outputs 0; counters and holding/shift registers cleared.

Timing base:
- Tick counter runs 0..BIT_DIV-1 while busy.
- Bit boundary occurs at tick == BIT_DIV-1.
- mod_bit is registered and held constant for BIT_DIV cycles.

States:
- IDLE: start=1 at cycle t latches len. At t+1: state PREAMBLE, mod_en=1, busy=1, mod_bit=1, underrun cleared. start while busy is ignored.
- PREAMBLE: bit k = ~k[0], so the pattern is 1,0,1,0,... After PREAMBLE_BITS bits go to SYNC.
- SYNC: SYNC_WORD[SYNC_LEN-1] first, down to bit 0. Then go to PAYLOAD if len != 0, else TAIL.
- PAYLOAD: shift register is loaded from the holding register at each byte boundary and sent MSB-first. After len bytes go to TAIL.
  - If the holding register is empty at a byte boundary: set underrun, go directly to TAIL, send 0.
- TAIL: TAIL_BITS zeros. On the final bit boundary: mod_en=0, busy=0, done=1 for one cycle, return to IDLE.

Frame length:
- Without underrun, mod_en is high for exactly (PREAMBLE_BITS+SYNC_LEN+8*len+TAIL_BITS)*BIT_DIV cycles.

Byte handshake:
- byte_ready = busy & holding-register empty & (bytes_fetched < len) & state != TAIL.
- A transfer occurs on byte_valid & byte_ready.
- Holding register empties on the same cycle it loads the shift register. A simultaneous handshake and load is not possible, because ready requires empty.
- Bytes may be prefetched from the start of PREAMBLE onward.
- Bytes offered while ready=0 are not consumed.

Width rules:
- Bit counter wide enough for max(PREAMBLE_BITS, SYNC_LEN, TAIL_BITS, 8).
- Byte counter is 8 bits; len = 255 is valid.

Reset mid-frame:
- mod_en drops immediately (asynchronous).
- No done pulse; underrun cleared.

Decomposition:
- Package oqpsk_pkg: state enum (IDLE, PREAMBLE, SYNC, PAYLOAD, TAIL) and default constants (BIT_DIV, preamble, sync word, tail).
- One sub-module: oqpsk_bit_tick (parameterised divider producing the bit-boundary strobe, cleared while not busy).
- FSM, holding register and shift register stay in the top module.

Test Plan:
- Reset check: drive RST=0 during an active frame -> mod_en, busy, done, underrun all 0 immediately. After release, a start is accepted normally.
- Basic frame: BIT_DIV=4, len=2, bytes 8'hA5, 8'h3C supplied promptly -> mod_en high for (32+16+16+16)*4=320 cycles. Bit stream is 1010... (32), then D391 MSB-first, then A5, 3C, then 16 zeros. done pulses once on the cycle mod_en falls.
- Zero-length frame: len=0 -> byte_ready never asserts. PREAMBLE->SYNC->TAIL; mod_en high for 64*BIT_DIV cycles.
- Underrun: len=3, supply only the first byte -> underrun=1 at the second byte boundary. Next 16 bits are zeros, then done. Total frame (32+16+8+16)*BIT_DIV. underrun stays set until the next accepted start.
- Backpressure: byte_valid held high with a stream of bytes -> exactly len transfers occur; byte_ready is never high while the holding register is full.
- Start while busy: pulse start mid-payload -> ignored. Frame length unchanged; no second frame begins after done.

Source files
------------

// File: rtl/oqpsk_pkg.sv
// Shared types and default framing constants for the OQPSK frame sequencer.
// The constants match the modulator's default framing.
package oqpsk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD,
    TAIL
  } state_t;

  localparam int          DEF_BIT_DIV       = 8;
  localparam int          DEF_PREAMBLE_BITS = 32;
  localparam int          DEF_SYNC_LEN      = 16;
  localparam logic [31:0] DEF_SYNC_WORD     = 32'h0000D391;
  localparam int          DEF_TAIL_BITS     = 16;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/oqpsk_frame_ctrl_bit_tick.sv
// Bit-period divider: strobes on the last clock of every BIT_DIV-clock bit.
// The strobe is held clear while the frame is not active.
module oqpsk_bit_tick #(
  parameter int BIT_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_stb
);

  localparam int TW = $clog2(BIT_DIV);

  logic [TW-1:0] tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else if (!en || tick_q == TW'(BIT_DIV - 1)) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  assign bit_stb = en && (tick_q == TW'(BIT_DIV - 1));

endmodule

// File: rtl/oqpsk_frame_ctrl.sv
// Frame sequencer for the OQPSK modulator: preamble, sync word, payload
// (MSB-first) and zero tail on mod_bit, with mod_en gating the whole frame.
module oqpsk_frame_ctrl
  import oqpsk_pkg::*;
#(
  parameter int          BIT_DIV       = DEF_BIT_DIV,
  parameter int          PREAMBLE_BITS = DEF_PREAMBLE_BITS,
  parameter int          SYNC_LEN      = DEF_SYNC_LEN,
  parameter logic [31:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter int          TAIL_BITS     = DEF_TAIL_BITS
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       mod_en,
  output logic       mod_bit,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int BITS_MAX = max4(PREAMBLE_BITS, SYNC_LEN, TAIL_BITS, 8);
  localparam int CW       = $clog2(BITS_MAX);

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_lim;
  logic [7:0]    len_q;
  logic [7:0]    fetched_q;
  logic [7:0]    sent_q;
  logic [7:0]    hold_q;
  logic          hold_full;
  logic [7:0]    pay_sr;
  logic [31:0]   sync_sr;
  logic          bit_stb;
  logic          bit_last;
  logic          need_byte;
  logic          load_byte;
  logic          miss_byte;
  logic          byte_xfer;

  oqpsk_bit_tick #(
    .BIT_DIV (BIT_DIV)
  ) u_bit_tick (
    .clk     (CLK),
    .rst_n   (RST),
    .en      (busy),
    .bit_stb (bit_stb)
  );

  assign busy       = (state_q != IDLE);
  assign byte_ready = busy && !hold_full && (fetched_q < len_q) && (state_q != TAIL);
  assign byte_xfer  = byte_valid && byte_ready;

  always_comb begin
    bit_lim   = '0;
    state_d   = state_q;
    case (state_q)
      PREAMBLE: bit_lim = CW'(PREAMBLE_BITS - 1);
      SYNC:     bit_lim = CW'(SYNC_LEN - 1);
      PAYLOAD:  bit_lim = CW'(7);
      TAIL:     bit_lim = CW'(TAIL_BITS - 1);
      default:  bit_lim = '0;
    endcase

    bit_last  = bit_stb && (bit_cnt == bit_lim);
    // A byte is needed when sync ends with payload pending or a byte ends short of len.
    need_byte = bit_last && (((state_q == SYNC) && (len_q != 8'd0)) ||
                             ((state_q == PAYLOAD) && (sent_q != len_q)));
    load_byte = need_byte && hold_full;
    miss_byte = need_byte && !hold_full;

    case (state_q)
      IDLE:     if (start)    state_d = PREAMBLE;
      PREAMBLE: if (bit_last) state_d = SYNC;
      SYNC:     if (bit_last) state_d = load_byte ? PAYLOAD : TAIL;
      PAYLOAD:  if (bit_last && !load_byte) state_d = TAIL;
      TAIL:     if (bit_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt   <= '0;
      len_q     <= '0;
      fetched_q <= '0;
      sent_q    <= '0;
      hold_q    <= '0;
      hold_full <= 1'b0;
      pay_sr    <= '0;
      sync_sr   <= '0;
      mod_en    <= 1'b0;
      mod_bit   <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          len_q     <= len;
          fetched_q <= '0;
          sent_q    <= '0;
          hold_full <= 1'b0;
          bit_cnt   <= '0;
          mod_en    <= 1'b1;
          mod_bit   <= 1'b1;
          underrun  <= 1'b0;
        end
      end else begin
        if (byte_xfer) begin
          hold_q    <= byte_data;
          hold_full <= 1'b1;
          fetched_q <= fetched_q + 8'd1;
        end
        if (load_byte) begin
          pay_sr    <= {hold_q[6:0], 1'b0};
          hold_full <= 1'b0;
          sent_q    <= sent_q + 8'd1;
        end
        if (miss_byte) underrun <= 1'b1;

        if (bit_stb) begin
          bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
          case (state_q)
            PREAMBLE: begin
              if (bit_last) begin
                mod_bit <= SYNC_WORD[SYNC_LEN-1];
                sync_sr <= SYNC_WORD << 1;
              end else begin
                mod_bit <= ~mod_bit;
              end
            end
            SYNC: begin
              if (bit_last) begin
                mod_bit <= load_byte & hold_q[7];
              end else begin
                mod_bit <= sync_sr[SYNC_LEN-1];
                sync_sr <= sync_sr << 1;
              end
            end
            PAYLOAD: begin
              if (bit_last) begin
                mod_bit <= load_byte & hold_q[7];
              end else begin
                mod_bit <= pay_sr[7];
                pay_sr  <= pay_sr << 1;
              end
            end
            TAIL: begin
              mod_bit <= 1'b0;
              // The last tail bit has flushed the filter; release the modulator.
              if (bit_last) begin
                mod_en <= 1'b0;
                done   <= 1'b1;
              end
            end
            default: mod_bit <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_oqpsk_frame_ctrl.sv
// Directed bench for oqpsk_frame_ctrl with BIT_DIV=4 and default framing.
module tb_oqpsk_frame_ctrl;

  localparam int BD = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic [7:0] byte_data = 8'd0;
  logic       byte_valid = 1'b0;
  logic       byte_ready, mod_en, mod_bit, busy, done, underrun;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_bytes [0:7];
  logic       cap_bits [0:255];
  logic       exp_bits [0:255];
  int         exp_n;

  int m_en, m_done, m_done_fall, m_nbits, m_xfers, m_rdy_full, m_rdy_cyc, m_und_first, m_und_end;

  oqpsk_frame_ctrl #(
    .BIT_DIV       (BD),
    .PREAMBLE_BITS (32),
    .SYNC_LEN      (16),
    .SYNC_WORD     (32'h0000D391),
    .TAIL_BITS     (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .len        (len),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mod_en     (mod_en),
    .mod_bit    (mod_bit),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 CLK = ~CLK;

  // Expected serial stream: 32 alternating bits, D391 MSB-first, nb bytes, 16 zeros.
  task automatic build_expected(input int nb);
    logic [15:0] sw;
    logic [7:0]  b8;
    sw = 16'hD391;
    exp_n = 0;
    for (int k = 0; k < 32; k++) begin
      exp_bits[exp_n] = (k % 2 == 0);
      exp_n++;
    end
    for (int i = 15; i >= 0; i--) begin
      exp_bits[exp_n] = sw[i];
      exp_n++;
    end
    for (int b = 0; b < nb; b++) begin
      b8 = tx_bytes[b];
      for (int i = 7; i >= 0; i--) begin
        exp_bits[exp_n] = b8[i];
        exp_n++;
      end
    end
    for (int k = 0; k < 16; k++) begin
      exp_bits[exp_n] = 1'b0;
      exp_n++;
    end
  endtask

  // Runs one frame from IDLE, offering n_supply bytes, and records what it observes.
  task automatic run_frame(input int n_len, input int n_supply, input int start_again_at);
    int   idx, post;
    logic prev_x, prev_en, seen_done;
    logic [2:0] bi;
    idx = 0; post = 0; prev_x = 1'b0; prev_en = 1'b0; seen_done = 1'b0;
    m_en = 0; m_done = 0; m_done_fall = 0; m_nbits = 0; m_xfers = 0;
    m_rdy_full = 0; m_rdy_cyc = 0; m_und_first = -1; m_und_end = -1;
    @(negedge CLK);
    len = n_len[7:0];
    start = 1'b1;
    byte_valid = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (mod_en) begin
        if (m_en == 0) m_und_first = int'(underrun);
        if (m_en % BD == 1) begin
          if (m_nbits < 256) cap_bits[m_nbits] = mod_bit;
          m_nbits++;
        end
        m_en++;
      end
      if (done) begin
        m_done++;
        if (prev_en && !mod_en) m_done_fall++;
        seen_done = 1'b1;
      end
      prev_en = mod_en;
      if (seen_done) post++;
      if (post > 20) break;
      start = (cyc == start_again_at);
      bi = idx[2:0];
      byte_valid = (idx < n_supply);
      byte_data = tx_bytes[bi];
      #1;
      if (prev_x && byte_ready) m_rdy_full++;
      if (byte_ready) m_rdy_cyc++;
      prev_x = byte_valid && byte_ready;
      if (prev_x) begin
        idx++;
        m_xfers++;
      end
      @(negedge CLK);
    end
    start = 1'b0;
    byte_valid = 1'b0;
    m_und_end = int'(underrun);
  endtask

  task automatic test_reset();
    checks++;
    if ({mod_en, busy, done, underrun, byte_ready, mod_bit} !== 6'b0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=000000", {mod_en, busy, done, underrun, byte_ready, mod_bit});
    end
    @(negedge CLK);
    RST = 1'b1;
    // Frame with missing payload so underrun is set before the mid-frame reset.
    @(negedge CLK);
    len = 8'd3;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (210) @(negedge CLK);
    checks++;
    if ({busy, underrun} !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset_busy_underrun got=%b exp=11", {busy, underrun});
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({mod_en, busy, done, underrun} !== 4'b0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%b exp=0000", {mod_en, busy, done, underrun});
    end
    @(negedge CLK);
    RST = 1'b1;
    run_frame(0, 0, -1);
    checks++;
    if (m_en != 64 * BD || m_done != 1) begin
      failures++;
      $display("FAIL post_reset_frame en_cycles=%0d done=%0d exp=%0d/1", m_en, m_done, 64 * BD);
    end
  endtask

  task automatic test_basic();
    int bad;
    run_frame(2, 2, -1);
    build_expected(2);
    bad = 0;
    for (int i = 0; i < exp_n; i++) if (cap_bits[i] !== exp_bits[i]) bad++;
    checks++;
    if (m_en != 320) begin
      failures++;
      $display("FAIL basic_en_cycles got=%0d exp=320", m_en);
    end
    checks++;
    if (m_nbits != exp_n || bad != 0) begin
      failures++;
      $display("FAIL basic_bitstream bits=%0d bad=%0d exp_bits=%0d bad=0", m_nbits, bad, exp_n);
    end
    checks++;
    if (m_done != 1 || m_done_fall != 1) begin
      failures++;
      $display("FAIL basic_done got=%0d/%0d exp=1/1", m_done, m_done_fall);
    end
    checks++;
    if (m_xfers != 2 || m_und_end != 0) begin
      failures++;
      $display("FAIL basic_xfers_underrun got=%0d/%0d exp=2/0", m_xfers, m_und_end);
    end
  endtask

  task automatic test_zero_len();
    int bad;
    run_frame(0, 4, -1);
    build_expected(0);
    bad = 0;
    for (int i = 0; i < exp_n; i++) if (cap_bits[i] !== exp_bits[i]) bad++;
    checks++;
    if (m_en != 64 * BD) begin
      failures++;
      $display("FAIL zero_en_cycles got=%0d exp=%0d", m_en, 64 * BD);
    end
    checks++;
    if (m_rdy_cyc != 0 || m_xfers != 0) begin
      failures++;
      $display("FAIL zero_ready got=%0d/%0d exp=0/0", m_rdy_cyc, m_xfers);
    end
    checks++;
    if (m_nbits != exp_n || bad != 0) begin
      failures++;
      $display("FAIL zero_bitstream bits=%0d bad=%0d exp_bits=%0d bad=0", m_nbits, bad, exp_n);
    end
  endtask

  task automatic test_underrun();
    int bad;
    run_frame(3, 1, -1);
    build_expected(1);
    bad = 0;
    for (int i = 0; i < exp_n; i++) if (cap_bits[i] !== exp_bits[i]) bad++;
    checks++;
    if (m_en != 72 * BD) begin
      failures++;
      $display("FAIL underrun_en_cycles got=%0d exp=%0d", m_en, 72 * BD);
    end
    checks++;
    if (m_nbits != exp_n || bad != 0) begin
      failures++;
      $display("FAIL underrun_bitstream bits=%0d bad=%0d exp_bits=%0d bad=0", m_nbits, bad, exp_n);
    end
    checks++;
    if (m_und_end != 1 || m_done != 1) begin
      failures++;
      $display("FAIL underrun_sticky got=%0d done=%0d exp=1/1", m_und_end, m_done);
    end
    run_frame(0, 0, -1);
    checks++;
    if (m_und_first != 0 || m_und_end != 0) begin
      failures++;
      $display("FAIL underrun_clear got=%0d/%0d exp=0/0", m_und_first, m_und_end);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    run_frame(3, 6, -1);
    build_expected(3);
    bad = 0;
    for (int i = 0; i < exp_n; i++) if (cap_bits[i] !== exp_bits[i]) bad++;
    checks++;
    if (m_xfers != 3) begin
      failures++;
      $display("FAIL bp_transfers got=%0d exp=3", m_xfers);
    end
    checks++;
    if (m_rdy_full != 0) begin
      failures++;
      $display("FAIL bp_ready_when_full got=%0d exp=0", m_rdy_full);
    end
    checks++;
    if (m_en != 88 * BD || m_nbits != exp_n || bad != 0) begin
      failures++;
      $display("FAIL bp_frame en=%0d bits=%0d bad=%0d exp=%0d/%0d/0", m_en, m_nbits, bad, 88 * BD, exp_n);
    end
  endtask

  task automatic test_start_while_busy();
    run_frame(2, 2, 200);
    checks++;
    if (m_en != 320 || m_done != 1) begin
      failures++;
      $display("FAIL start_busy en_cycles=%0d done=%0d exp=320/1", m_en, m_done);
    end
    checks++;
    if (busy !== 1'b0 || mod_en !== 1'b0) begin
      failures++;
      $display("FAIL start_busy_idle got=%b exp=00", {busy, mod_en});
    end
  endtask

  initial begin
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C; tx_bytes[2] = 8'hF0; tx_bytes[3] = 8'h0F;
    tx_bytes[4] = 8'h81; tx_bytes[5] = 8'h7E; tx_bytes[6] = 8'h55; tx_bytes[7] = 8'hC3;
    repeat (3) @(negedge CLK);
    test_reset();
    test_basic();
    test_zero_len();
    test_underrun();
    test_backpressure();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
